// File: rtl/ro_pair_compare_if.sv
// Request/response bus between a challenge issuer and the ring-oscillator pair comparator.
// Latency: none (wiring only); the comparator answers SETTLE+WINDOW+2 cycles after start.
// Backpressure: none; the issuer watches busy, and starts issued while busy are dropped.
interface ro_pair_compare_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic [3:0]       challenge_a;
    logic [3:0]       challenge_b;
    logic             busy;
    logic             resp_valid;
    logic             resp;
    logic             tie;
    logic [CNT_W-1:0] count_a;
    logic [CNT_W-1:0] count_b;

    // Issuer side: drives the challenge and receives the response.
    modport master (
        output start, challenge_a, challenge_b,
        input  busy, resp_valid, resp, tie, count_a, count_b
    );

    // Comparator side.
    modport slave (
        input  start, challenge_a, challenge_b,
        output busy, resp_valid, resp, tie, count_a, count_b
    );
endinterface

// File: rtl/ro_pair_compare.sv
// Ring-oscillator pair comparator: counts ro_a/ro_b rising edges over a fixed window and compares them.
// Latency: a response pulse arrives SETTLE_CYCLES + WINDOW_CYCLES + 2 cycles after an accepted start.
// Backpressure: none; a start is taken only in IDLE, and starts while busy are ignored.
module ro_pair_compare #(
    parameter int WINDOW_CYCLES = 4096,
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ro_a,
    input  logic             ro_b,
    output logic [3:0]       sel_a,
    output logic [3:0]       sel_b,
    output logic             ro_en,
    ro_pair_compare_if.slave bus
);

    // One down-counter times both the settle and the count phases; it only has
    // to hold the larger reload value (length minus one).
    localparam int TMR_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] WINDOW_LOAD = TMR_W'(WINDOW_CYCLES - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETTLE  = 3'd1;
    localparam logic [2:0] S_COUNT   = 3'd2;
    localparam logic [2:0] S_COMPARE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_nxt;
    logic             accept;
    logic             timer_zero;

    // Synchronizer (s1, s2) and edge-history (s3) flops per oscillator.
    logic a_s1, a_s2, a_s3;
    logic b_s1, b_s2, b_s3;
    // Number of window cycles whose samples have reached the edge-history flop (saturates at 3).
    logic [1:0] fill;
    logic       edge_a;
    logic       edge_b;

    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    assign accept     = (state == S_IDLE) && bus.start;
    assign timer_zero = (timer == '0);

    // Phase sequencing: IDLE -> SETTLE -> COUNT -> COMPARE -> DONE -> IDLE.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = S_SETTLE;
                    timer_nxt = SETTLE_LOAD;
                end
            end
            S_SETTLE: begin
                if (timer_zero) begin
                    state_nxt = S_COUNT;
                    timer_nxt = WINDOW_LOAD;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            S_COUNT: begin
                if (timer_zero) begin
                    state_nxt = S_COMPARE;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            S_COMPARE: state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // State and phase timer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    // Mux selects are captured once per evaluation and frozen until the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_a <= 4'd0;
            sel_b <= 4'd0;
        end else if (accept) begin
            sel_a <= bus.challenge_a;
            sel_b <= bus.challenge_b;
        end
    end

    // Synchronizers run only during COUNT and sit at zero otherwise, so they are
    // cleared on every entry to COUNT and carry nothing over from SETTLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_s1 <= 1'b0;
            a_s2 <= 1'b0;
            a_s3 <= 1'b0;
            b_s1 <= 1'b0;
            b_s2 <= 1'b0;
            b_s3 <= 1'b0;
            fill <= 2'd0;
        end else if (state != S_COUNT) begin
            a_s1 <= 1'b0;
            a_s2 <= 1'b0;
            a_s3 <= 1'b0;
            b_s1 <= 1'b0;
            b_s2 <= 1'b0;
            b_s3 <= 1'b0;
            fill <= 2'd0;
        end else begin
            a_s1 <= ro_a;
            a_s2 <= a_s1;
            a_s3 <= a_s2;
            b_s1 <= ro_b;
            b_s2 <= b_s1;
            b_s3 <= b_s2;
            if (fill != 2'd3) begin
                fill <= fill + 2'd1;
            end
        end
    end

    // The cleared flops would look like a 0->1 step when the oscillator is already
    // high, so detection waits until s2 and s3 both hold real window samples.
    assign edge_a = (state == S_COUNT) && (fill == 2'd3) && a_s2 && !a_s3;
    assign edge_b = (state == S_COUNT) && (fill == 2'd3) && b_s2 && !b_s3;

    // Edge counters: cleared on accept, saturate at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else if (accept) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (edge_a && (cnt_a != '1)) begin
                cnt_a <= cnt_a + 1'b1;
            end
            if (edge_b && (cnt_b != '1)) begin
                cnt_b <= cnt_b + 1'b1;
            end
        end
    end

    // Results update only in COMPARE and hold across the following idle time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.count_a <= '0;
            bus.count_b <= '0;
            bus.resp    <= 1'b0;
            bus.tie     <= 1'b0;
        end else if (state == S_COMPARE) begin
            bus.count_a <= cnt_a;
            bus.count_b <= cnt_b;
            bus.resp    <= (cnt_a > cnt_b);
            bus.tie     <= (cnt_a == cnt_b);
        end
    end

    assign ro_en          = (state == S_SETTLE) || (state == S_COUNT);
    assign bus.busy       = (state != S_IDLE);
    assign bus.resp_valid = (state == S_DONE);

endmodule

// File: doc/ro_pair_compare.md
RO_PAIR_COMPARE -- requirements
Module: ro_pair_compare

Interface
REQ-001 Parameter WINDOW_CYCLES, default 4096: count window length in clk cycles (min 2).
REQ-002 Parameter SETTLE_CYCLES, default 16: oscillator settle time in clk cycles (min 1).
REQ-003 Parameter CNT_W, default 16: edge-counter width.
REQ-004 clk  input  1  single block clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle request to evaluate one challenge.
REQ-007 challenge_a  input  4  select for mux feeding ro_a.
REQ-008 challenge_b  input  4  select for mux feeding ro_b.
REQ-009 ro_a  input  1  output of mux_16to1 instance A; asynchronous to clk.
REQ-010 ro_b  input  1  output of mux_16to1 instance B; asynchronous to clk.
REQ-011 sel_a  output  4  registered select driven to mux A.
REQ-012 sel_b  output  4  registered select driven to mux B.
REQ-013 ro_en  output  1  ring-oscillator enable.
REQ-014 busy  output  1  high whenever FSM is not IDLE.
REQ-015 resp_valid  output  1  one-cycle pulse; resp, tie, count_a, count_b valid.
REQ-016 resp  output  1  response bit: 1 iff count_a > count_b.
REQ-017 tie  output  1  1 iff count_a == count_b.
REQ-018 count_a, count_b  output  CNT_W each  final edge counts, held until next resp_valid.

Function
REQ-019 FSM states: IDLE, SETTLE, COUNT, COMPARE, DONE.
REQ-020 IDLE: start=1 latches challenge_a/b into sel_a/sel_b, clears internal counters, loads timer, enters SETTLE next cycle.
REQ-021 start while busy=1 is ignored; sel_a/sel_b remain stable from latch until return to IDLE.
REQ-022 ro_en = 1 in SETTLE and COUNT only; 0 in all other states.
REQ-023 SETTLE lasts exactly SETTLE_CYCLES cycles; no edges counted; then COUNT.
REQ-024 ro_a and ro_b each pass a 2-flop synchronizer, then rising-edge detect against a third flop.
REQ-025 Synchronizer and edge-detect flops are cleared on entry to COUNT; no edge is counted on COUNT's first cycle.
REQ-026 COUNT lasts exactly WINDOW_CYCLES cycles; each detected rising edge increments its counter by 1.
REQ-027 Counters saturate at 2^CNT_W-1; no wrap.
REQ-028 COMPARE lasts one cycle: computes resp and tie, registers count_a/count_b to outputs.
REQ-029 DONE lasts one cycle: resp_valid=1; then IDLE. Earliest next start accepted in the IDLE cycle that follows.
REQ-030 Start-to-resp_valid latency: SETTLE_CYCLES + WINDOW_CYCLES + 2 cycles.
REQ-031 Ties give resp=0, tie=1; both counters saturated counts as a tie.
REQ-032 resp, tie, count_a, count_b change only in COMPARE and otherwise hold.

Reset
REQ-033 rst_n low, at any time including mid-COUNT, forces immediately: state IDLE, ro_en=0, busy=0, resp_valid=0, resp=0, tie=0, sel_a=sel_b=0, count_a=count_b=0, internal counters and synchronizers 0.
REQ-034 A start on the first clk edge after rst_n deasserts is accepted.

Verification
REQ-035 Parameters WINDOW=100, SETTLE=4; start with challenge 3/9; ro_a period 4 clk, ro_b period 5 clk -> resp_valid at cycle 106, count_a≈25 > count_b≈20, resp=1, tie=0.
REQ-036 Identical ro_a/ro_b period 6 clk -> count_a==count_b, resp=0, tie=1.
REQ-037 CNT_W=4, ro_a toggling every clk, WINDOW=100 -> count_a=15 (saturated), no wrap.
REQ-038 Second start pulse mid-COUNT with new challenge -> ignored, sel_a/sel_b unchanged, single resp_valid.
REQ-039 rst_n low for 1 cycle mid-COUNT -> ro_en=0 and busy=0 immediately, no resp_valid; next start completes normally.
REQ-040 ro_a held constant 1 through window, ro_b held 0 -> count_a=0, count_b=0, tie=1 (no spurious edge at COUNT entry).
